rom_stream_reader: RTL and testbench

Address sequencer and output buffer for single_port_rom_async. It sits directly upstream of the ROM: it drives rom_addr, samples the ROM's combinational output rom_q, and presents the words as a valid/ready stream. The block supports one-shot and looping sweeps over a programmable address window [first_addr..last_addr].

---
 rtl/rom_stream_reader.sv | 138 +++++++++++++
 tb/tb_rom_stream_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: address sequencer and output buffer sitting in front of
// an asynchronous-read ROM. It walks the window [first_addr..last_addr], with
// wrap through the top of the address space, and presents the words as a
// valid/ready stream. The sweep is either one-shot or looping.
//
// Optional build macro: ROM_READER_CHECKSUM_EN. When it is defined, the block
// adds a "checksum" output. That output is the modulo-2**DATA_WIDTH sum of
// every word the downstream consumer accepts.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; window registers hold the last sweep's values
// S_RUN   | fetching words; loads the output register whenever it is free
// S_DRAIN | final word is loaded; waiting for it to be accepted, then done

module rom_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  loop,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic [ADDR_WIDTH-1:0]   first_q;
  logic [ADDR_WIDTH-1:0]   last_q;
  logic                    loop_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    load_d;
  logic [ADDR_WIDTH-1:0]   addr_inc_d;

  // The output register may take a new word when it is empty or is being drained this cycle.
  assign load_d     = !m_valid_q || m_ready;
  // Natural overflow gives the wrap through the top of the address space.
  assign addr_inc_d = rom_addr_q + ADDR_WIDTH'(1);

  // Sweep FSM; every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      first_q    <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            first_q    <= first_addr;
            last_q     <= last_addr;
            loop_q     <= loop;
            rom_addr_q <= first_addr;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (load_d) begin
            m_data_q  <= rom_q;
            m_valid_q <= 1'b1;
            if (rom_addr_q != last_q) begin
              rom_addr_q <= addr_inc_d;
            end else if (loop_q && !stop) begin
              rom_addr_q <= first_q;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  // Running sum of accepted words; cleared by an accepted start, then held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      checksum_q <= '0;
    end else if (m_valid_q && m_ready) begin
      checksum_q <= checksum_q + m_data_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader. It drives the block against a behavioural
// ROM holding ED,B7,18,E7,CC,0F,F0,AA.
module tb_rom_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [2:0] first_addr;
  logic [2:0] last_addr;
  logic       loop;
  logic [2:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
`ifdef ROM_READER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks;
  int failures;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt;
  int         done_at;
  int         first_acc;
  int         last_acc;

  rom_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .loop       (loop),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
`ifdef ROM_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rom_q = 8'h00;
    case (rom_addr)
      3'd0: rom_q = 8'hED;
      3'd1: rom_q = 8'hB7;
      3'd2: rom_q = 8'h18;
      3'd3: rom_q = 8'hE7;
      3'd4: rom_q = 8'hCC;
      3'd5: rom_q = 8'h0F;
      3'd6: rom_q = 8'hF0;
      3'd7: rom_q = 8'hAA;
      default: rom_q = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [2:0] f, input logic [2:0] l, input logic lp);
    first_addr = f;
    last_addr  = l;
    loop       = lp;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Samples n cycles, recording accepted words and done pulses; optionally pulses
  // start at cycle pulse_at and raises stop from cycle stop_at.
  task automatic collect(input int n, input int pulse_at, input int stop_at);
    got_q.delete();
    done_cnt  = 0;
    done_at   = -1;
    first_acc = -1;
    last_acc  = -1;
    for (int i = 0; i < n; i++) begin
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (first_acc < 0) first_acc = i;
        last_acc = i;
      end
      start = (i == pulse_at);
      if (i == pulse_at) begin
        first_addr = 3'd3;
        last_addr  = 3'd7;
        loop       = 1'b1;
      end
      if (i == stop_at) stop = 1'b1;
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic verify(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i),
          (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD, {24'h0, exp_q[i]});
    end
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " done_lat"}, done_at, last_acc + 1);
    chk({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    loop       = 1'b0;
    first_addr = 3'd0;
    last_addr  = 3'd0;
    m_ready    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst rom_addr", rom_addr, 3'd0);
    chk("rst m_valid", m_valid, 1'b0);
    chk("rst m_data", m_data, 8'h00);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);

    // Async reset in the middle of a sweep.
    start_sweep(3'd2, 3'd6, 1'b0);
    tick();
    tick();
    chk("mid busy", busy, 1'b1);
    chk("mid m_valid", m_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #2;
    chk("arst m_valid", m_valid, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst rom_addr", rom_addr, 3'd0);
    chk("arst m_data", m_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // Full sweep, always ready.
    start_sweep(3'd0, 3'd7, 1'b0);
    chk("full rom_addr0", rom_addr, 3'd0);
    chk("full busy", busy, 1'b1);
    collect(14, -1, -1);
    exp_q = '{8'hED, 8'hB7, 8'h18, 8'hE7, 8'hCC, 8'h0F, 8'hF0, 8'hAA};
    verify("full");
    chk("full first_lat", first_acc, 1);
    chk("full consecutive", last_acc - first_acc, 7);
`ifdef ROM_READER_CHECKSUM_EN
    chk("full checksum", checksum, 8'h18);
`endif

    // Backpressure on the first word.
    m_ready = 1'b0;
    start_sweep(3'd2, 3'd4, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold_data%0d", k), m_data, 8'h18);
      chk($sformatf("bp hold_valid%0d", k), m_valid, 1'b1);
      tick();
    end
    m_ready = 1'b1;
    collect(10, -1, -1);
    exp_q = '{8'h18, 8'hE7, 8'hCC};
    verify("bp");

    // Wrapped window, with a start pulse that must be ignored while busy.
    start_sweep(3'd6, 3'd1, 1'b0);
    collect(12, 2, -1);
    exp_q = '{8'hF0, 8'hAA, 8'hED, 8'hB7};
    verify("wrap");

    // Looping window, stop raised during the third pass.
    start_sweep(3'd3, 3'd4, 1'b1);
    collect(14, -1, 4);
    exp_q = '{8'hE7, 8'hCC, 8'hE7, 8'hCC, 8'hE7, 8'hCC};
    verify("loop");

    // Single-word window.
    start_sweep(3'd5, 3'd5, 1'b0);
    collect(6, -1, -1);
    exp_q = '{8'h0F};
    verify("single");
    chk("single done_at", done_at, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
